// File: rtl/calc_pkg.sv
// Shared definitions for the truth-table sweep block and its calc stage.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } calcState_t;

   localparam int          CALC_NUM_COMBOS = 4;
   localparam logic [7:0]  CALC_GATE_MASK  = 8'h7F;
   localparam logic [31:0] CALC_TT_GOLDEN  = 32'h134A4E74;

   // Expected gate-result byte for operand combination i = {comA,comB}.
   function automatic logic [7:0] goldenByte(input logic [1:0] i);
      logic [31:0] sh;
      sh = CALC_TT_GOLDEN >> {i, 3'b000};
      return sh[7:0];
   endfunction

endpackage

// File: rtl/calc_sweep.sv
// Drives all four {comA,comB} operand combinations into the calc stage,
// captures the gate results into a truth table and compares them against
// the golden table. Every output is registered.
module calc_sweep
   import calc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  outC,
   output logic        comA,
   output logic        comB,
   output logic        busy,
   output logic        done,
   output logic [31:0] tt,
   output logic [6:0]  err,
   output logic        pass
);

   localparam logic [1:0] LAST_IDX = 2'(CALC_NUM_COMBOS - 1);

   calcState_t state;
   logic [1:0] idx;
   logic [7:0] gateVal;
   logic [7:0] goldVal;
   logic [6:0] errNext;

   // outC[7] is not a gate output; masking here keeps it out of tt, err and pass.
   assign gateVal = outC & CALC_GATE_MASK;
   assign goldVal = goldenByte(idx);
   // Accumulated mismatch flags including the combination being sampled now,
   // so pass can be registered on the same edge as the final sample.
   assign errNext = err | (gateVal[6:0] ^ goldVal[6:0]);

   // Sweep sequencer: operand drive, settle, sample, and completion pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 2'd0;
         comA  <= 1'b0;
         comB  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         tt    <= 32'h0;
         err   <= 7'h0;
         pass  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= DRIVE;
                  idx         <= 2'd0;
                  {comA,comB} <= 2'b00;
                  err         <= 7'h0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            // One settle cycle with operands stable before sampling.
            DRIVE: state <= SAMPLE;
            SAMPLE: begin
               tt[{idx, 3'b000} +: 8] <= gateVal;
               err                    <= errNext;
               if (idx == LAST_IDX) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (errNext == 7'h0);
               end else begin
                  idx         <= idx + 2'd1;
                  {comA,comB} <= idx + 2'd1;
                  state       <= DRIVE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sweep.sv
// Directed bench for calc_sweep with a behavioural calc stage that can
// force gate bit3 low and drive outC[7] as 0, X or 1.
module tb_calc_sweep;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  outC;
   logic        comA, comB, busy, done, pass;
   logic [31:0] tt;
   logic [6:0]  err;

   int nChecks = 0;
   int nPass   = 0;

   // Calc-stage fault controls.
   logic       forceBit3 = 1'b0;
   int         bit7Mode  = 0;   // 0: drive 0, 1: drive X, 2: drive 1
   logic [31:0] goldTab  = 32'h134A4E74;

   calc_sweep dut (
      .clk(clk), .rst(rst), .start(start), .outC(outC),
      .comA(comA), .comB(comB), .busy(busy), .done(done),
      .tt(tt), .err(err), .pass(pass)
   );

   always #5 clk = ~clk;

   // Behavioural calc stage: golden gate results for the current operands.
   always_comb begin
      logic [31:0] sh;
      sh   = goldTab >> {comA, comB, 3'b000};
      outC = sh[7:0];
      if (forceBit3) outC[3] = 1'b0;
      case (bit7Mode)
         1:       outC[7] = 1'bx;
         2:       outC[7] = 1'b1;
         default: outC[7] = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic        fBit3;
      int          b7;
      logic [31:0] expTt;
      logic [6:0]  expErr;
      logic        expPass;
   } vec_t;

   vec_t vecs[4];

   // Start a sweep at cycle T and check every cycle through T+10.
   task automatic runSweep(input string tag);
      @(negedge clk) start = 1'b1;
      for (int off = 1; off <= 10; off++) begin
         @(negedge clk);
         start = 1'b0;
         if (off <= 8)
            chk($sformatf("%s com@%0d", tag, off), {30'h0, comA, comB}, 32'((off - 1) / 2));
         chk($sformatf("%s done@%0d", tag, off), {31'h0, done}, {31'h0, off == 9});
         chk($sformatf("%s busy@%0d", tag, off), {31'h0, busy}, {31'h0, off <= 8});
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      vecs[0] = '{1'b0, 0, 32'h134A4E74, 7'h00, 1'b1};
      vecs[1] = '{1'b1, 0, 32'h13424674, 7'h08, 1'b0};
      vecs[2] = '{1'b0, 1, 32'h134A4E74, 7'h00, 1'b1};
      vecs[3] = '{1'b0, 2, 32'h134A4E74, 7'h00, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset outs", {24'h0, comA, comB, busy, done, pass, 3'b0}, 32'h0);
      chk("reset tt", tt, 32'h0);
      chk("reset err", {25'h0, err}, 32'h0);
      @(negedge clk) rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         forceBit3 = vecs[v].fBit3;
         bit7Mode  = vecs[v].b7;
         runSweep($sformatf("v%0d", v));
         chk($sformatf("v%0d tt", v), tt, vecs[v].expTt);
         chk($sformatf("v%0d err", v), {25'h0, err}, {25'h0, vecs[v].expErr});
         chk($sformatf("v%0d pass", v), {31'h0, pass}, {31'h0, vecs[v].expPass});
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d tt hold", v), tt, vecs[v].expTt);
         chk($sformatf("v%0d pass hold", v), {31'h0, pass}, {31'h0, vecs[v].expPass});
      end
      bit7Mode = 0;

      // tt is overwritten per byte, not cleared; err/pass clear at start.
      forceBit3 = 1'b1;
      runSweep("pre");
      forceBit3 = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;                 // T+1
      chk("ovr tt@1", tt, 32'h13424674);
      chk("ovr err@1", {25'h0, err}, 32'h0);
      chk("ovr pass@1", {31'h0, pass}, 32'h0);
      repeat (4) @(negedge clk);                   // T+5
      chk("ovr tt@5", tt, 32'h13424E74);
      repeat (5) @(negedge clk);                   // T+10
      chk("ovr tt end", tt, 32'h134A4E74);
      chk("ovr pass end", {31'h0, pass}, 32'h1);

      // start held for 20 cycles: two back-to-back sweeps.
      @(negedge clk) start = 1'b1;
      for (int off = 1; off <= 21; off++) begin
         @(negedge clk);
         if (off >= 19) start = 1'b0;
         if (off <= 20) begin
            chk($sformatf("hold done@%0d", off), {31'h0, done}, {31'h0, off == 9 || off == 19});
            chk($sformatf("hold busy@%0d", off), {31'h0, busy},
                {31'h0, !(off == 9 || off == 10 || off >= 19)});
         end else begin
            chk("hold busy@21", {31'h0, busy}, 32'h0);
         end
      end
      chk("hold tt", tt, 32'h134A4E74);

      // Reset during cycle T+5 aborts the sweep.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;                 // T+1
      repeat (3) @(negedge clk);                   // T+4
      @(negedge clk) rst = 1'b1;                   // T+5
      @(negedge clk) rst = 1'b0;                   // T+6
      chk("abort outs", {24'h0, comA, comB, busy, done, pass, 3'b0}, 32'h0);
      chk("abort tt", tt, 32'h0);
      chk("abort err", {25'h0, err}, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("abort nodone%0d", k), {30'h0, done, busy}, 32'h0);
      end
      runSweep("post");
      chk("post tt", tt, 32'h134A4E74);
      chk("post pass", {31'h0, pass}, 32'h1);

      // rst wins over start in IDLE.
      @(negedge clk) begin rst = 1'b1; start = 1'b1; end
      @(negedge clk) begin rst = 1'b0; start = 1'b0; end
      chk("rst+start busy", {31'h0, busy}, 32'h0);
      chk("rst+start com", {30'h0, comA, comB}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("rst+start idle", {30'h0, busy, done}, 32'h0);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
